stream_mux: RTL
===============

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter N, default 3: data width per channel in bits.
REQ-002 Parameter CH, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter SW, default $clog2(CH): select and channel-index width; derived, not overridden.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-008 sel  input  SW  channel index used when mode=0.
REQ-009 in_data  input  CH*N  packed channel data; channel k occupies bits [k*N +: N].
REQ-010 in_valid  input  CH  per-channel valid.
REQ-011 in_ready  output  CH  per-channel ready; one-hot or zero.
REQ-012 out_data  output  N  registered output data.
REQ-013 out_chan  output  SW  index of the channel that supplied out_data.
REQ-014 out_valid  output  1  output holds an unconsumed beat.
REQ-015 out_ready  input  1  downstream accepts the beat.

Function
REQ-016 A beat from channel k transfers when in_valid[k] and in_ready[k] are both high on a rising clk edge.
REQ-017 The output SHALL be a single-entry register with 1-cycle latency: the beat accepted at edge t appears on out_data, out_chan and out_valid after edge t.
REQ-018 slot_free = !out_valid | out_ready.
REQ-019 in_ready[k] SHALL be high only when slot_free is high and k is the granted channel.
REQ-020 The block SHALL hold no more than one beat and SHALL NOT drop or duplicate a beat.
REQ-021 mode=0: grant = sel when sel < CH and in_valid[sel] is high; otherwise no grant. Out-of-range sel never grants.
REQ-022 mode=1: grant SHALL be the first valid channel at or after rr_ptr, searching upward and wrapping from CH-1 to 0.
REQ-023 rr_ptr SHALL update to (granted+1) mod CH only on a transfer. It SHALL NOT change in mode 0 or when no transfer occurs.
REQ-024 Simultaneous out_ready and a new accept in the same cycle: the output register SHALL be reloaded with no bubble cycle.
REQ-025 out_valid=1 with out_ready=0: out_data and out_chan SHALL stay stable and all in_ready SHALL be low.
REQ-026 No valid input and out_ready=1: out_valid SHALL fall on the next edge.
REQ-027 mode and sel are sampled combinationally each cycle. A change takes effect on the next arbitration and SHALL NOT disturb a beat already held in the output register.
REQ-028 in_ready SHALL depend combinationally on in_valid, mode, sel, out_valid, out_ready and rr_ptr. It SHALL NOT depend on in_data.

Reset
REQ-029 While rst_n=0: out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
REQ-030 While rst_n=0: in_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard any held beat immediately and asynchronously. The first grant after release SHALL use rr_ptr=0.

Structure
REQ-032 A shared package SHALL hold the mode constants MODE_FIXED=0 and MODE_RR=1.
REQ-033 The same package SHALL hold a function computing the wrap-around first-set search.
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arbiter. It takes request vector, pointer and enable, and returns a one-hot grant, grant index and grant-valid.
REQ-035 All datapath widths SHALL follow N, CH and SW. There SHALL be no hard-coded widths.

Verification (N=3, CH=4)
REQ-036 Fixed mode, latency: mode=0, sel=2, in_valid=4'b0100, channel 2 data=3'd5, out_ready=1. Required: in_ready=4'b0100; next cycle out_data=5, out_chan=2, out_valid=1.
REQ-037 Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1, five cycles. Required: out_chan sequence 0,1,2,3,0.
REQ-038 Backpressure: out_valid=1 holding data 3 from channel 1, out_ready=0 for 3 cycles. Required: in_ready=0, out_data=3, out_chan=1 stable; out_ready=1 then transfers, with the new beat loaded in the same edge.
REQ-039 Out-of-range select: sel=3 with CH=3, mode=0, in_valid=3'b111. Required: in_ready=0 and out_valid falls to 0.
REQ-040 Reset mid-stream: rst_n low while out_valid=1 and rr_ptr=2. Required: out_valid=0 immediately. After release with all channels valid in mode 1, first out_chan=0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode constants and wrap-around first-set search
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Search helpers are sized for the largest legal channel count.
  localparam int MAX_CH = 16;
  localparam int MAX_SW = 4;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping from ch-1 back to 0.
  function automatic rr_pick_t rr_first_set(input logic [MAX_CH-1:0] req,
                                            input logic [MAX_SW-1:0] ptr,
                                            input int                ch);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      k = int'(ptr) + i;
      if (k >= ch) k = k - ch;
      if (i < ch && !r.found && req[k]) begin
        r.found = 1'b1;
        r.idx   = k[MAX_SW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - round-robin grant from request vector and pointer
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CH = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [CH-1:0] grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_valid
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick = rr_first_set(MAX_CH'(req), MAX_SW'(ptr), CH);
  end

  assign grant_valid = en && w_pick.found;
  assign grant_idx   = w_pick.idx[SW-1:0];

  always_comb begin
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - CH-to-1 stream mux with fixed/round-robin select and one-beat output register
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N  = 3,
  parameter int CH = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;
  logic          r_out_valid;
  logic [SW-1:0] r_rr_ptr;

  logic [CH-1:0] w_rr_grant;
  logic [SW-1:0] w_rr_idx;
  logic          w_rr_valid;
  logic [CH-1:0] w_fix_grant;
  logic [CH-1:0] w_grant;
  logic [SW-1:0] w_grant_idx;
  logic          w_grant_valid;
  logic          w_slot_free;
  logic          w_xfer;
  logic          w_is_rr;

  assign w_is_rr     = (mode == MODE_RR);
  assign w_slot_free = !r_out_valid || out_ready;

  rr_arbiter #(.CH(CH), .SW(SW)) u_rr_arbiter (
    .req        (in_valid),
    .ptr        (r_rr_ptr),
    .en         (w_is_rr),
    .grant      (w_rr_grant),
    .grant_idx  (w_rr_idx),
    .grant_valid(w_rr_valid)
  );

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    w_fix_grant = '0;
    for (int k = 0; k < CH; k++) begin
      w_fix_grant[k] = (sel == SW'(k)) && in_valid[k];
    end
  end

  assign w_grant       = w_is_rr ? w_rr_grant : w_fix_grant;
  assign w_grant_idx   = w_is_rr ? w_rr_idx   : sel;
  assign w_grant_valid = |w_grant;

  assign in_ready = (rst_n && w_slot_free) ? w_grant : '0;
  assign w_xfer   = rst_n && w_slot_free && w_grant_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= in_data[w_grant_idx*N +: N];
        r_out_chan  <= w_grant_idx;
        r_out_valid <= 1'b1;
        if (w_is_rr) begin
          r_rr_ptr <= (w_grant_idx == SW'(CH-1)) ? '0 : w_grant_idx + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
